cc_miss_ctrl: RTL and testbench



---
 rtl/cc_miss_ctrl_if.sv | 63 ++++++
 rtl/cc_miss_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cc_miss_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_miss_ctrl_if.sv
// Bus bundle for cc_miss_ctrl: request channel, tag/data SRAM port,
// memory read channel and response FIFO push port.
//   slave  : modport seen by cc_miss_ctrl
//   master : modport seen by the surrounding environment
// Parameters: ADDR_W (address width), IDX_W (set-index width).
interface cc_miss_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 9
);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 6;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned RESP_W = LINE_W + 3;

    // request channel
    logic [ADDR_W-1:0] inct_araddr_i;
    logic              inct_arvalid_i;
    logic              inct_arready_o;
    // tag/data SRAM
    logic [IDX_W-1:0]  sram_addr_o;
    logic              sram_rden_o;
    logic              sram_wren_o;
    logic [TAG_W-1:0]  tag_rdata_i;
    logic              valid_rdata_i;
    logic [LINE_W-1:0] data_rdata_i;
    logic [TAG_W-1:0]  tag_wdata_o;
    logic [LINE_W-1:0] data_wdata_o;
    // memory read channel
    logic [ADDR_W-1:0] mem_araddr_o;
    logic              mem_arvalid_o;
    logic              mem_arready_i;
    logic [BEAT_W-1:0] mem_rdata_i;
    logic              mem_rvalid_i;
    logic              mem_rlast_i;
    logic              mem_rready_o;
    // response FIFO
    logic              fifo_full_i;
    logic              fifo_afull_i;
    logic              fifo_wren_o;
    logic [RESP_W-1:0] fifo_wdata_o;

    modport slave (
        input  inct_araddr_i, inct_arvalid_i,
        output inct_arready_o,
        output sram_addr_o, sram_rden_o, sram_wren_o, tag_wdata_o, data_wdata_o,
        input  tag_rdata_i, valid_rdata_i, data_rdata_i,
        output mem_araddr_o, mem_arvalid_o, mem_rready_o,
        input  mem_arready_i, mem_rdata_i, mem_rvalid_i, mem_rlast_i,
        input  fifo_full_i, fifo_afull_i,
        output fifo_wren_o, fifo_wdata_o
    );

    modport master (
        output inct_araddr_i, inct_arvalid_i,
        input  inct_arready_o,
        input  sram_addr_o, sram_rden_o, sram_wren_o, tag_wdata_o, data_wdata_o,
        output tag_rdata_i, valid_rdata_i, data_rdata_i,
        input  mem_araddr_o, mem_arvalid_o, mem_rready_o,
        output mem_arready_i, mem_rdata_i, mem_rvalid_i, mem_rlast_i,
        output fifo_full_i, fifo_afull_i,
        input  fifo_wren_o, fifo_wdata_o
    );
endinterface

// File: rtl/cc_miss_ctrl.sv
// cc_miss_ctrl: read-path request sequencer of the cache controller.
// Accepts one line read at a time, looks up the direct-mapped tag/data
// SRAMs, refills from memory (8 x 64-bit beats) on a miss and pushes
// {word offset, line} into the response FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ctrl_if    : cc_miss_ctrl_if.slave (request, SRAM, memory, FIFO)
// Optional build macro CC_MISS_CTRL_STATS_EN adds:
//   stat_hit_o[31:0], stat_miss_o[31:0] : saturating lookup counters
//   rlast_err_o                         : sticky rlast/beat-7 mismatch
module cc_miss_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    cc_miss_ctrl_if.slave ctrl_if
`ifdef CC_MISS_CTRL_STATS_EN
    ,
    output logic [31:0]   stat_hit_o,
    output logic [31:0]   stat_miss_o,
    output logic          rlast_err_o
`endif
);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 6;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned BEAT_W = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_FILL = 3'd3,
        REFILL   = 3'd4,
        PUSH     = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        woff_q, woff_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [2:0]        beat_q, beat_d;

    logic arready_c;
    logic accept_c;
    logic hit_c;
    logic beat_acc_c;
    logic last_beat_c;
    logic unused_bits;

    // Accept gating: only in IDLE, never while reset is asserted, and only
    // when the FIFO is guaranteed to have room for the eventual push.
    assign arready_c   = rst_n && (state_q == IDLE) && !ctrl_if.fifo_afull_i;
    assign accept_c    = arready_c && ctrl_if.inct_arvalid_i;
    assign hit_c       = ctrl_if.valid_rdata_i && (ctrl_if.tag_rdata_i == tag_q);
    assign beat_acc_c  = (state_q == MEM_FILL) && ctrl_if.mem_rvalid_i;
    // Fill length is counted, rlast is not trusted to end it.
    assign last_beat_c = beat_acc_c && (beat_q == 3'd7);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept_c)                  state_d = LOOKUP;
            LOOKUP:   state_d = hit_c ? PUSH : MEM_REQ;
            MEM_REQ:  if (ctrl_if.mem_arready_i)     state_d = MEM_FILL;
            MEM_FILL: if (last_beat_c)               state_d = REFILL;
            REFILL:   state_d = PUSH;
            PUSH:     if (!ctrl_if.fifo_full_i)      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ctrl_if.inct_arready_o = arready_c;
        ctrl_if.sram_rden_o    = accept_c;
        // Index comes straight from the request on the accept cycle so the
        // SRAM data is ready in LOOKUP.
        ctrl_if.sram_addr_o    = accept_c ? ctrl_if.inct_araddr_i[IDX_W+5:6] : idx_q;
        ctrl_if.sram_wren_o    = 1'b0;
        ctrl_if.tag_wdata_o    = tag_q;
        ctrl_if.data_wdata_o   = line_q;
        ctrl_if.mem_araddr_o   = {tag_q, idx_q, 6'b000000};
        ctrl_if.mem_arvalid_o  = 1'b0;
        ctrl_if.mem_rready_o   = 1'b0;
        ctrl_if.fifo_wren_o    = 1'b0;
        ctrl_if.fifo_wdata_o   = {woff_q, line_q};
        unique case (state_q)
            MEM_REQ:  ctrl_if.mem_arvalid_o = 1'b1;
            MEM_FILL: ctrl_if.mem_rready_o  = 1'b1;
            REFILL:   ctrl_if.sram_wren_o   = 1'b1;
            PUSH:     ctrl_if.fifo_wren_o   = !ctrl_if.fifo_full_i;
            default:  ;
        endcase
    end

    // Request fields, line buffer and beat counter
    always_comb begin
        tag_d  = tag_q;
        idx_d  = idx_q;
        woff_d = woff_q;
        line_d = line_q;
        beat_d = beat_q;
        if (accept_c) begin
            tag_d  = ctrl_if.inct_araddr_i[ADDR_W-1:IDX_W+6];
            idx_d  = ctrl_if.inct_araddr_i[IDX_W+5:6];
            woff_d = ctrl_if.inct_araddr_i[5:3];
            beat_d = 3'd0;
        end
        if ((state_q == LOOKUP) && hit_c) begin
            line_d = ctrl_if.data_rdata_i;
        end
        if (beat_acc_c) begin
            line_d[{beat_q, 6'b000000} +: BEAT_W] = ctrl_if.mem_rdata_i;
            beat_d = beat_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q  <= '0;
            idx_q  <= '0;
            woff_q <= '0;
            line_q <= '0;
            beat_q <= '0;
        end else begin
            tag_q  <= tag_d;
            idx_q  <= idx_d;
            woff_q <= woff_d;
            line_q <= line_d;
            beat_q <= beat_d;
        end
    end

`ifdef CC_MISS_CTRL_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        rlast_err_q, rlast_err_d;

    // Saturating lookup counters and sticky rlast check
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rlast_err_d = rlast_err_q;
        if (state_q == LOOKUP) begin
            if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!hit_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
        if (beat_acc_c && (ctrl_if.mem_rlast_i != (beat_q == 3'd7))) begin
            rlast_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            rlast_err_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    assign stat_hit_o  = hit_cnt_q;
    assign stat_miss_o = miss_cnt_q;
    assign rlast_err_o = rlast_err_q;
    assign unused_bits = ^ctrl_if.inct_araddr_i[2:0];
`else
    assign unused_bits = ^{ctrl_if.inct_araddr_i[2:0], ctrl_if.mem_rlast_i};
`endif

endmodule

// File: tb/tb_cc_miss_ctrl.sv
// Directed self-checking bench for cc_miss_ctrl with a behavioural
// tag/data SRAM (one-cycle read latency) and a scripted memory.
module tb_cc_miss_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    cc_miss_ctrl_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

`ifdef CC_MISS_CTRL_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
    logic        rlast_err;
`endif

    cc_miss_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus)
`ifdef CC_MISS_CTRL_STATS_EN
        ,
        .stat_hit_o  (stat_hit),
        .stat_miss_o (stat_miss),
        .rlast_err_o (rlast_err)
`endif
    );

    // SRAM model: read data valid the cycle after rden, write on wren edge.
    logic [TAG_W-1:0] tag_mem   [512];
    bit               valid_mem [512];
    logic [511:0]     data_mem  [512];

    always @(posedge clk) begin
        if (bus.sram_wren_o) begin
            tag_mem[bus.sram_addr_o]   <= bus.tag_wdata_o;
            valid_mem[bus.sram_addr_o] <= 1'b1;
            data_mem[bus.sram_addr_o]  <= bus.data_wdata_o;
        end
        if (bus.sram_rden_o) begin
            bus.tag_rdata_i   <= tag_mem[bus.sram_addr_o];
            bus.valid_rdata_i <= valid_mem[bus.sram_addr_o];
            bus.data_rdata_i  <= data_mem[bus.sram_addr_o];
        end
    end

    task automatic check(input string tag, input logic [514:0] obs, input logic [514:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat(input logic [31:0] seed, input int k);
        return {seed, 32'h5A5A_0000 | 32'(k)};
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = beat(seed, k);
        return l;
    endfunction

    // Issue a request in IDLE; returns in the LOOKUP cycle.
    task automatic send_req(input logic [31:0] a);
        bus.inct_araddr_i  = a;
        bus.inct_arvalid_i = 1'b1;
        #1;
        check("accept_arready", 515'(bus.inct_arready_o), 515'(1));
        check("accept_rden", 515'(bus.sram_rden_o), 515'(1));
        check("accept_sram_addr", 515'(bus.sram_addr_o), 515'(a[14:6]));
        step();
        bus.inct_arvalid_i = 1'b0;
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic [511:0] line);
        send_req(a);
        step();
        check("hit_push_wren", 515'(bus.fifo_wren_o), 515'(1));
        check("hit_push_wdata", bus.fifo_wdata_o, {a[5:3], line});
        check("hit_no_memreq", 515'(bus.mem_arvalid_o), 515'(0));
        step();
        check("hit_idle_wren", 515'(bus.fifo_wren_o), 515'(0));
        check("hit_idle_arready", 515'(bus.inct_arready_o), 515'(1));
    endtask

    task automatic expect_miss(input logic [31:0] a, input logic [31:0] seed,
                               input int ar_delay, input bit gaps, input int early_last);
        logic [511:0] line;
        line = line_of(seed);
        send_req(a);
        step();
        check("miss_arvalid", 515'(bus.mem_arvalid_o), 515'(1));
        check("miss_araddr", 515'(bus.mem_araddr_o), 515'({a[31:6], 6'b000000}));
        for (int i = 0; i < ar_delay; i++) begin
            step();
            check("stall_arvalid", 515'(bus.mem_arvalid_o), 515'(1));
            check("stall_araddr", 515'(bus.mem_araddr_o), 515'({a[31:6], 6'b000000}));
        end
        bus.mem_arready_i = 1'b1;
        step();
        bus.mem_arready_i = 1'b0;
        check("fill_rready", 515'(bus.mem_rready_o), 515'(1));
        check("fill_arvalid_low", 515'(bus.mem_arvalid_o), 515'(0));
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
                step();
                check("gap_rready", 515'(bus.mem_rready_o), 515'(1));
            end
            bus.mem_rdata_i  = beat(seed, k);
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rlast_i  = (k == 7) || (k == early_last);
            #1;
            check("fill_no_wren", 515'(bus.sram_wren_o), 515'(0));
            step();
        end
        // Extra beat offered after the 8th must not be consumed.
        bus.mem_rdata_i = 64'hFFFF_0000_FFFF_0000;
        bus.mem_rlast_i = 1'b0;
        #1;
        check("refill_wren", 515'(bus.sram_wren_o), 515'(1));
        check("refill_addr", 515'(bus.sram_addr_o), 515'(a[14:6]));
        check("refill_tag", 515'(bus.tag_wdata_o), 515'(a[31:15]));
        check("refill_line", 515'(bus.data_wdata_o), 515'(line));
        check("refill_rready_low", 515'(bus.mem_rready_o), 515'(0));
        step();
        bus.mem_rvalid_i = 1'b0;
        check("miss_push_wren", 515'(bus.fifo_wren_o), 515'(1));
        check("miss_push_wdata", bus.fifo_wdata_o, {a[5:3], line});
        check("miss_push_no_sram_wr", 515'(bus.sram_wren_o), 515'(0));
        step();
        check("miss_idle_wren", 515'(bus.fifo_wren_o), 515'(0));
        check("miss_idle_arready", 515'(bus.inct_arready_o), 515'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arready"}, 515'(bus.inct_arready_o), 515'(0));
        check({tag, "_rden"}, 515'(bus.sram_rden_o), 515'(0));
        check({tag, "_sram_ctl"}, 515'({bus.sram_wren_o, bus.sram_addr_o, bus.tag_wdata_o}), 515'(0));
        check({tag, "_data_wdata"}, 515'(bus.data_wdata_o), 515'(0));
        check({tag, "_mem"}, 515'({bus.mem_arvalid_o, bus.mem_rready_o, bus.mem_araddr_o}), 515'(0));
        check({tag, "_fifo_wren"}, 515'(bus.fifo_wren_o), 515'(0));
        check({tag, "_fifo_wdata"}, bus.fifo_wdata_o, 515'(0));
    endtask

    initial begin
        bus.inct_araddr_i  = '0;
        bus.inct_arvalid_i = 1'b0;
        bus.mem_arready_i  = 1'b0;
        bus.mem_rdata_i    = '0;
        bus.mem_rvalid_i   = 1'b0;
        bus.mem_rlast_i    = 1'b0;
        bus.fifo_full_i    = 1'b0;
        bus.fifo_afull_i   = 1'b0;

        // Reset: outputs zero even with a request pending
        #2 rst_n = 1'b0;
        bus.inct_arvalid_i = 1'b1;
        bus.inct_araddr_i  = 32'h0000_1048;
        #1;
        check_all_zero("reset");
        step();
        check_all_zero("reset_edge");
        bus.inct_arvalid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
`ifdef CC_MISS_CTRL_STATS_EN
        check("stats_reset", 515'({stat_hit, stat_miss, rlast_err}), 515'(0));
`endif

        // Almost-full blocks accept
        bus.fifo_afull_i   = 1'b1;
        bus.inct_araddr_i  = 32'h0000_3000;
        bus.inct_arvalid_i = 1'b1;
        #1;
        check("afull_arready", 515'(bus.inct_arready_o), 515'(0));
        check("afull_rden", 515'(bus.sram_rden_o), 515'(0));
        step();
        check("afull_still_idle", 515'(bus.inct_arready_o), 515'(0));
        bus.inct_arvalid_i = 1'b0;
        bus.fifo_afull_i   = 1'b0;
        #1;
        check("afull_release", 515'(bus.inct_arready_o), 515'(1));

        // Cold miss, then hit on the refilled line
        expect_miss(32'h0000_1048, 32'hA000_0001, 0, 1'b0, -1);
        expect_hit(32'h0000_1078, line_of(32'hA000_0001));

        // Conflict miss with memory stalls, then original tag misses again
        // (rlast asserted early on beat 3 must not cut the fill short)
        expect_miss(32'h0000_9040, 32'hB000_0002, 4, 1'b1, -1);
        expect_miss(32'h0000_1040, 32'hC000_0003, 0, 1'b0, 3);

        // FIFO full in PUSH for 5 cycles
        send_req(32'h0000_1040);
        bus.fifo_full_i = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("full_no_wren", 515'(bus.fifo_wren_o), 515'(0));
            check("full_wdata_stable", bus.fifo_wdata_o, {3'd0, line_of(32'hC000_0003)});
            check("full_not_idle", 515'(bus.inct_arready_o), 515'(0));
            step();
        end
        bus.fifo_full_i = 1'b0;
        #1;
        check("full_release_wren", 515'(bus.fifo_wren_o), 515'(1));
        step();
        check("full_single_push", 515'(bus.fifo_wren_o), 515'(0));
        check("full_back_idle", 515'(bus.inct_arready_o), 515'(1));
`ifdef CC_MISS_CTRL_STATS_EN
        check("stats_hit", 515'(stat_hit), 515'(2));
        check("stats_miss", 515'(stat_miss), 515'(3));
        check("stats_rlast_err", 515'(rlast_err), 515'(1));
`endif

        // Reset during the 4th fill beat
        send_req(32'h0000_2000);
        step();
        check("rst_miss_arvalid", 515'(bus.mem_arvalid_o), 515'(1));
        bus.mem_arready_i = 1'b1;
        step();
        bus.mem_arready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_rdata_i  = beat(32'hD000_0004, k);
            bus.mem_rvalid_i = 1'b1;
            step();
        end
        bus.mem_rdata_i = beat(32'hD000_0004, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midfill_reset");
        step();
        check_all_zero("midfill_reset_edge");
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_no_sram_wr", 515'(bus.sram_wren_o), 515'(0));
            check("post_reset_no_push", 515'(bus.fifo_wren_o), 515'(0));
            check("post_reset_no_memreq", 515'(bus.mem_arvalid_o), 515'(0));
        end
        // No partial refill happened, so the line still misses
        expect_miss(32'h0000_2000, 32'hE000_0005, 1, 1'b0, -1);
`ifdef CC_MISS_CTRL_STATS_EN
        check("stats_after_reset", 515'({stat_hit, stat_miss, rlast_err}), 515'({32'd0, 32'd1, 1'b0}));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
